// File: rtl/conv_window_addr_gen_pkg.sv
// Shared definitions for the convolution window address generator:
// FSM state encoding and a constant-safe ceil(log2) helper.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } conv_state_e;

  // Never returns less than 1, so a single-value range still gets a 1-bit counter.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_window_addr_gen_if.sv
// Address beat stream from the window sequencer to the pixel RAM / MAC array.
interface conv_window_addr_gen_if #(
  parameter int ADDR_W = 4,
  parameter int TAP_W  = 4
);

  // A beat transfers on a rising clock edge where addr_valid and addr_ready are both
  // high; once raised, addr_valid and the payload hold steady until that transfer.
  logic              addr_valid;
  logic              addr_ready;
  logic [ADDR_W-1:0] addr;
  logic [TAP_W-1:0]  tap_idx;
  logic              win_first;
  logic              win_last;
  logic              addr_pad;

  modport master (
    output addr_valid, addr, tap_idx, win_first, win_last, addr_pad,
    input  addr_ready
  );

  modport slave (
    input  addr_valid, addr, tap_idx, win_first, win_last, addr_pad,
    output addr_ready
  );

endinterface

// File: rtl/conv_window_addr_gen_axis_counter.sv
// Wrapping 0..MAX-1 counter; wrap flags the enabled step that returns to 0 so
// counters can be chained innermost to outermost.
module conv_axis_counter #(
  parameter int MAX = 4,
  parameter int W   = 2
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         wrap
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic         at_max;

  assign at_max = (q_q == W'(MAX - 1));

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = at_max ? '0 : q_q + W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign wrap = en & at_max;

endmodule

// File: rtl/conv_window_addr_gen.sv
// Sliding KxK window pixel-address sequencer. Optional WIN_PAD_EN macro selects a
// "same"-size scan with K/2 zero padding; otherwise only fully in-image windows are walked.
module conv_window_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4,
  parameter int K      = 3,
  parameter int STRIDE = 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    start,
  conv_window_addr_gen_if.master  bus,
  output logic                    busy,
  output logic                    done,
  output conv_state_e             state_dbg
);

  localparam int ADDR_W = clog2(IMG_W * IMG_H);
  localparam int TAP_W  = clog2(K * K);
`ifdef WIN_PAD_EN
  localparam int PAD    = K / 2;
  localparam int NWC    = (IMG_W + STRIDE - 1) / STRIDE;
  localparam int NWR    = (IMG_H + STRIDE - 1) / STRIDE;
  localparam int CW     = ADDR_W + 2;
`else
  localparam int PAD    = 0;
  localparam int NWC    = (IMG_W - K) / STRIDE + 1;
  localparam int NWR    = (IMG_H - K) / STRIDE + 1;
  localparam int CW     = ADDR_W + 1;
`endif
  localparam int TC_W   = clog2(K);
  localparam int WC_W   = clog2(NWC);
  localparam int WR_W   = clog2(NWR);

  conv_state_e       state_q, state_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              pad_q, pad_d;
  logic              frame_last_q, frame_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              adv;
  logic              cnt_clr;
  logic [TC_W-1:0]   tc, tr;
  logic [WC_W-1:0]   wc;
  logic [WR_W-1:0]   wr;
  logic              tc_wrap, tr_wrap, wc_wrap, wr_wrap;

  logic [CW-1:0]     row_c, col_c, lin_c;
  logic [ADDR_W-1:0] nx_addr;
  logic [TAP_W-1:0]  nx_tap;
  logic              nx_first, nx_last, nx_pad;

  // Counters always hold the coordinates of the next beat to be loaded into the
  // output registers; they advance exactly when a beat is loaded.
  assign adv = ((state_q == ST_IDLE) && start) ||
               ((state_q == ST_RUN) && valid_q && bus.addr_ready && !frame_last_q);
  assign cnt_clr = (state_q == ST_DONE);

  conv_axis_counter #(.MAX(K),   .W(TC_W)) u_tc (
    .CLK(CLK), .RESET(RESET), .en(adv),     .clr(cnt_clr), .q(tc), .wrap(tc_wrap)
  );
  conv_axis_counter #(.MAX(K),   .W(TC_W)) u_tr (
    .CLK(CLK), .RESET(RESET), .en(tc_wrap), .clr(cnt_clr), .q(tr), .wrap(tr_wrap)
  );
  conv_axis_counter #(.MAX(NWC), .W(WC_W)) u_wc (
    .CLK(CLK), .RESET(RESET), .en(tr_wrap), .clr(cnt_clr), .q(wc), .wrap(wc_wrap)
  );
  conv_axis_counter #(.MAX(NWR), .W(WR_W)) u_wr (
    .CLK(CLK), .RESET(RESET), .en(wc_wrap), .clr(cnt_clr), .q(wr), .wrap(wr_wrap)
  );

  always_comb begin
    row_c = CW'(wr) * CW'(STRIDE) + CW'(tr) - CW'(PAD);
    col_c = CW'(wc) * CW'(STRIDE) + CW'(tc) - CW'(PAD);
    lin_c = row_c * CW'(IMG_W) + col_c;
`ifdef WIN_PAD_EN
    // A negative coordinate wraps to a huge unsigned value, so one compare per axis
    // catches both the leading and the trailing border.
    nx_pad = (row_c >= CW'(IMG_H)) | (col_c >= CW'(IMG_W));
`else
    nx_pad = 1'b0;
`endif
    nx_addr  = nx_pad ? '0 : ADDR_W'(lin_c);
    nx_tap   = TAP_W'(tr) * TAP_W'(K) + TAP_W'(tc);
    nx_first = (tr == '0) && (tc == '0);
    nx_last  = (tr == TC_W'(K - 1)) && (tc == TC_W'(K - 1));
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    addr_d       = addr_q;
    tap_d        = tap_q;
    first_d      = first_q;
    last_d       = last_q;
    pad_d        = pad_q;
    frame_last_d = frame_last_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (valid_q && bus.addr_ready && frame_last_q) begin
          state_d = ST_DONE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          addr_d  = '0;
          tap_d   = '0;
          first_d = 1'b0;
          last_d  = 1'b0;
          pad_d   = 1'b0;
          frame_last_d = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // The full carry chain fires only on the step that loads the frame's final beat.
    if (adv) begin
      addr_d       = nx_addr;
      tap_d        = nx_tap;
      first_d      = nx_first;
      last_d       = nx_last;
      pad_d        = nx_pad;
      frame_last_d = wr_wrap;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      valid_q      <= 1'b0;
      addr_q       <= '0;
      tap_q        <= '0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      pad_q        <= 1'b0;
      frame_last_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      tap_q        <= tap_d;
      first_q      <= first_d;
      last_q       <= last_d;
      pad_q        <= pad_d;
      frame_last_q <= frame_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.addr_valid = valid_q;
  assign bus.addr       = addr_q;
  assign bus.tap_idx    = tap_q;
  assign bus.win_first  = first_q;
  assign bus.win_last   = last_q;
  assign bus.addr_pad   = pad_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Scoreboard bench for conv_window_addr_gen: a 4x4/K3/S1 instance and an 8x6/K3/S2 instance.
module tb_conv_window_addr_gen;
  import conv_pkg::*;

  localparam int AW_A = clog2(4 * 4);
  localparam int AW_B = clog2(8 * 6);
  localparam int TW   = clog2(9);
  localparam int BW   = 27;
`ifdef WIN_PAD_EN
  localparam int PAD_EN = 1;
`else
  localparam int PAD_EN = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start_a = 1'b0, start_b = 1'b0;
  logic        ready_a = 1'b1, ready_b = 1'b1;
  logic        rmode_a = 1'b0, rmode_b = 1'b0;
  logic        busy_a, done_a, busy_b, done_b;
  conv_state_e st_a, st_b;

  conv_window_addr_gen_if #(.ADDR_W(AW_A), .TAP_W(TW)) bus_a ();
  conv_window_addr_gen_if #(.ADDR_W(AW_B), .TAP_W(TW)) bus_b ();
  assign bus_a.addr_ready = ready_a;
  assign bus_b.addr_ready = ready_b;

  conv_window_addr_gen #(.IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1)) dut_a (
    .CLK(clk), .RESET(rst), .start(start_a), .bus(bus_a),
    .busy(busy_a), .done(done_a), .state_dbg(st_a)
  );
  conv_window_addr_gen #(.IMG_W(8), .IMG_H(6), .K(3), .STRIDE(2)) dut_b (
    .CLK(clk), .RESET(rst), .start(start_b), .bus(bus_b),
    .busy(busy_b), .done(done_b), .state_dbg(st_b)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [BW-1:0] exp_qa[$];
  logic [BW-1:0] exp_qb[$];
  logic [BW-1:0] log_a[0:299];
  logic [BW-1:0] log_b[0:299];
  logic [BW-1:0] cur_a, cur_b, held_a, held_b;
  logic hold_a = 1'b0, hold_b = 1'b0;
  int acc_a = 0, acc_b = 0, done_cnt_a = 0, done_cnt_b = 0;
  int last_acc_a = 0, last_acc_b = 0;
  int w0_addr[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int w0_pad[9]  = '{1, 1, 1, 1, 0, 0, 1, 0, 0};

  function automatic logic [BW-1:0] pack(input int addr, input int tap,
                                         input bit f, input bit l, input bit p);
    return {p, l, f, tap[7:0], addr[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference walk: nested loops over windows and taps, independent of the DUT counters.
  task automatic push_frame(input int sel, input int iw, input int ih, input int k,
                            input int s, output int nbeats);
    int p, nwc, nwr, r, c, a;
    bit pd;
    p   = PAD_EN ? k / 2 : 0;
    nwc = PAD_EN ? (iw + s - 1) / s : (iw - k) / s + 1;
    nwr = PAD_EN ? (ih + s - 1) / s : (ih - k) / s + 1;
    nbeats = 0;
    for (int wr = 0; wr < nwr; wr++)
      for (int wc = 0; wc < nwc; wc++)
        for (int tr = 0; tr < k; tr++)
          for (int tc = 0; tc < k; tc++) begin
            r  = wr * s + tr - p;
            c  = wc * s + tc - p;
            pd = (r < 0) || (r >= ih) || (c < 0) || (c >= iw);
            a  = pd ? 0 : r * iw + c;
            if (sel == 0)
              exp_qa.push_back(pack(a, tr * k + tc, (tr == 0) && (tc == 0),
                                    (tr == k - 1) && (tc == k - 1), pd));
            else
              exp_qb.push_back(pack(a, tr * k + tc, (tr == 0) && (tc == 0),
                                    (tr == k - 1) && (tc == k - 1), pd));
            nbeats++;
          end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst) begin
      hold_a = 1'b0;
    end else begin
      cur_a = pack(int'(bus_a.addr), int'(bus_a.tap_idx), bus_a.win_first,
                   bus_a.win_last, bus_a.addr_pad);
      if (hold_a) begin
        chk("a_hold_valid", 32'(bus_a.addr_valid), 32'd1);
        if (bus_a.addr_valid) chk("a_hold_beat", 32'(cur_a), 32'(held_a));
      end
      if (bus_a.addr_valid) begin
        if (ready_a) begin
          if (exp_qa.size() == 0) chk("a_extra_beat", 32'(cur_a), 32'hFFFF_FFFF);
          else chk("a_beat", 32'(cur_a), 32'(exp_qa.pop_front()));
          if (acc_a < 300) log_a[acc_a] = cur_a;
          acc_a++;
          last_acc_a = cyc;
          hold_a = 1'b0;
        end else begin
          hold_a = 1'b1;
          held_a = cur_a;
        end
      end else begin
        hold_a = 1'b0;
      end
      if (done_a) begin
        chk("a_done_gap", 32'(cyc - last_acc_a), 32'd1);
        done_cnt_a++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      hold_b = 1'b0;
    end else begin
      cur_b = pack(int'(bus_b.addr), int'(bus_b.tap_idx), bus_b.win_first,
                   bus_b.win_last, bus_b.addr_pad);
      if (hold_b) begin
        chk("b_hold_valid", 32'(bus_b.addr_valid), 32'd1);
        if (bus_b.addr_valid) chk("b_hold_beat", 32'(cur_b), 32'(held_b));
      end
      if (bus_b.addr_valid) begin
        if (ready_b) begin
          if (exp_qb.size() == 0) chk("b_extra_beat", 32'(cur_b), 32'hFFFF_FFFF);
          else chk("b_beat", 32'(cur_b), 32'(exp_qb.pop_front()));
          if (acc_b < 300) log_b[acc_b] = cur_b;
          acc_b++;
          last_acc_b = cyc;
          hold_b = 1'b0;
        end else begin
          hold_b = 1'b1;
          held_b = cur_b;
        end
      end else begin
        hold_b = 1'b0;
      end
      if (done_b) begin
        chk("b_done_gap", 32'(cyc - last_acc_b), 32'd1);
        done_cnt_b++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ready_a = rmode_a ? 1'($urandom_range(0, 1)) : 1'b1;
      ready_b = rmode_b ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic pulse_start_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
  endtask

  task automatic wait_done_a(input int target, input string name);
    int t;
    t = 0;
    while (done_cnt_a < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk(name, 32'(done_cnt_a), 32'(target));
  endtask

  task automatic wait_done_b(input int target, input string name);
    int t;
    t = 0;
    while (done_cnt_b < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk(name, 32'(done_cnt_b), 32'(target));
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_valid"}, 32'(bus_a.addr_valid), 32'd0);
    chk({tag, "_addr"},  32'(bus_a.addr),       32'd0);
    chk({tag, "_tap"},   32'(bus_a.tap_idx),    32'd0);
    chk({tag, "_first"}, 32'(bus_a.win_first),  32'd0);
    chk({tag, "_last"},  32'(bus_a.win_last),   32'd0);
    chk({tag, "_pad"},   32'(bus_a.addr_pad),   32'd0);
    chk({tag, "_busy"},  32'(busy_a),           32'd0);
    chk({tag, "_done"},  32'(done_a),           32'd0);
    chk({tag, "_state"}, 32'(st_a),             32'(ST_IDLE));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n, d0, g, t;

    repeat (3) @(posedge clk);
    #1;
    chk_zero_a("rst");
    chk("rst_b_valid", 32'(bus_b.addr_valid), 32'd0);
    chk("rst_b_busy",  32'(busy_b),           32'd0);
    rst = 1'b0;

    // T1: single frame, ready always high
    acc_a = 0;
    push_frame(0, 4, 4, 3, 1, n);
    pulse_start_a();
    chk("t1_busy", 32'(busy_a), 32'd1);
    chk("t1_state_run", 32'(st_a), 32'(ST_RUN));
    wait_done_a(1, "t1_done");
    chk("t1_beats", 32'(acc_a), 32'(n));
    chk("t1_q_empty", 32'(exp_qa.size()), 32'd0);
`ifdef WIN_PAD_EN
    chk("t5_count", 32'(acc_a), 32'd144);
    for (int i = 0; i < 9; i++) chk("t5_w0_pad", 32'(log_a[i][26]), 32'(w0_pad[i]));
    chk("t5_unpad_a0", 32'(log_a[4][15:0]), 32'd0);
    chk("t5_unpad_a1", 32'(log_a[5][15:0]), 32'd1);
    chk("t5_unpad_a4", 32'(log_a[7][15:0]), 32'd4);
    chk("t5_unpad_a5", 32'(log_a[8][15:0]), 32'd5);
`else
    chk("t1_count", 32'(acc_a), 32'd36);
    for (int i = 0; i < 9; i++) chk("t1_w0_addr", 32'(log_a[i][15:0]), 32'(w0_addr[i]));
    chk("t1_end_addr", 32'(log_a[35][15:0]), 32'd15);
    chk("t1_end_last", 32'(log_a[35][25]), 32'd1);
    for (int i = 0; i < 4; i++) chk("t1_win_first", 32'(log_a[i * 9][24]), 32'd1);
`endif

    // T2: random backpressure, same sequence
    rmode_a = 1'b1;
    acc_a = 0;
    push_frame(0, 4, 4, 3, 1, n);
    pulse_start_a();
    wait_done_a(2, "t2_done");
    chk("t2_beats", 32'(acc_a), 32'(n));
    chk("t2_q_empty", 32'(exp_qa.size()), 32'd0);
    rmode_a = 1'b0;

    // T3: reset mid-frame, then restart
    acc_a = 0;
    push_frame(0, 4, 4, 3, 1, n);
    pulse_start_a();
    t = 0;
    while (acc_a < 20 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("t3_reach_beat20", 32'(acc_a >= 20), 32'd1);
    chk("t3_busy_pre", 32'(busy_a), 32'd1);
    #2 rst = 1'b1;
    #1 chk_zero_a("t3_rst");
    exp_qa.delete();
    d0 = done_cnt_a;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("t3_no_done", 32'(done_cnt_a), 32'(d0));
    acc_a = 0;
    push_frame(0, 4, 4, 3, 1, n);
    pulse_start_a();
    wait_done_a(d0 + 1, "t3_done");
    chk("t3_restart_addr", 32'(log_a[0][15:0]), 32'd0);
    chk("t3_restart_tap",  32'(log_a[0][23:16]), 32'd0);
    chk("t3_beats", 32'(acc_a), 32'(n));
    chk("t3_q_empty", 32'(exp_qa.size()), 32'd0);

    // T4: 8x6 image, stride 2, random backpressure
    rmode_b = 1'b1;
    acc_b = 0;
    push_frame(1, 8, 6, 3, 2, n);
    pulse_start_b();
    wait_done_b(1, "t4_done");
    chk("t4_beats", 32'(acc_b), 32'(n));
    chk("t4_q_empty", 32'(exp_qb.size()), 32'd0);
`ifndef WIN_PAD_EN
    chk("t4_count", 32'(acc_b), 32'd54);
    chk("t4_lastwin_addr", 32'(log_b[45][15:0]), 32'd20);
    chk("t4_lastwin_first", 32'(log_b[45][24]), 32'd1);
`endif
    rmode_b = 1'b0;

    // T6: start held high -> back-to-back frames with a 2-cycle gap
    acc_a = 0;
    push_frame(0, 4, 4, 3, 1, n);
    push_frame(0, 4, 4, 3, 1, n);
    d0 = done_cnt_a;
    @(posedge clk); #1 start_a = 1'b1;
    t = 0;
    while (!done_a && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("t6_first_done", 32'(done_a), 32'd1);
    g = 0;
    while (!bus_a.addr_valid && g < 10) begin
      g++;
      @(negedge clk);
    end
    chk("t6_gap", 32'(g), 32'd2);
    start_a = 1'b0;
    wait_done_a(d0 + 2, "t6_done");
    repeat (5) @(negedge clk);
    chk("t6_no_third", 32'(bus_a.addr_valid), 32'd0);
    chk("t6_beats", 32'(acc_a), 32'(2 * n));
    chk("t6_q_empty", 32'(exp_qa.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
